// File: rtl/instruction_fetch.sv
// Instruction fetch stage: PC generation, 1-cycle synchronous imem interface and a
// 2-entry {instr, pc} buffer presented to decode over valid/ready, with redirect flush.
module instruction_fetch #(
    parameter int unsigned     PC_W     = 64,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    input  logic            redirect_valid,
    input  logic [PC_W-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_instr,
    output logic [PC_W-1:0] out_pc,
    output logic [6:0]      out_opcode
);

    logic [PC_W-1:0] fetch_pc;
    logic [PC_W-1:0] inflight_pc;
    logic            inflight;
    logic [1:0]      count;
    logic [31:0]     instr_q [2];
    logic [PC_W-1:0] pc_q    [2];

    logic            pop;
    logic            push;
    logic            push_slot;
    logic [2:0]      occupancy;
    logic [PC_W-1:0] redirect_aligned;

    assign out_valid = (count != 2'd0);
    assign pop       = out_valid & out_ready;
    assign push      = inflight & ~redirect_valid;
    assign occupancy = {1'b0, count} + {2'b00, inflight};

    // occupancy - pop < 2, rearranged to avoid an unsigned underflow
    assign imem_req  = reset & ~redirect_valid & (occupancy < (3'd2 + {2'b00, pop}));
    assign imem_addr = fetch_pc;

    // Entry 0 is always the head; a push lands in the first slot left free after any pop
    assign push_slot = (count == 2'd2) || ((count == 2'd1) && !pop);

    assign redirect_aligned = redirect_pc & ~{{(PC_W-2){1'b0}}, 2'b11};

    assign out_instr  = out_valid ? instr_q[0] : '0;
    assign out_pc     = out_valid ? pc_q[0]    : '0;
    assign out_opcode = out_instr[6:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc    <= RESET_PC;
            inflight_pc <= '0;
            inflight    <= 1'b0;
            count       <= 2'd0;
            instr_q[0]  <= '0;
            instr_q[1]  <= '0;
            pc_q[0]     <= '0;
            pc_q[1]     <= '0;
        end else if (redirect_valid) begin
            fetch_pc <= redirect_aligned;
            inflight <= 1'b0;
            count    <= 2'd0;
        end else begin
            inflight <= imem_req;
            if (imem_req) begin
                fetch_pc    <= fetch_pc + PC_W'(4);
                inflight_pc <= fetch_pc;
            end
            if (pop) begin
                instr_q[0] <= instr_q[1];
                pc_q[0]    <= pc_q[1];
            end
            // Later assignment overrides the shift when push and pop target slot 0
            if (push) begin
                if (push_slot) begin
                    instr_q[1] <= imem_rdata;
                    pc_q[1]    <= inflight_pc;
                end else begin
                    instr_q[0] <= imem_rdata;
                    pc_q[0]    <= inflight_pc;
                end
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: queue-based model of issued-but-undelivered
// fetches, checked every cycle under directed and randomized ready/redirect traffic.
module tb_instruction_fetch;

    localparam logic [63:0] WRAP_PC = 64'hFFFF_FFFF_FFFF_FFFC;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic [31:0] imem_rdata = '0;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_instr;
    logic [63:0] out_pc;
    logic [6:0]  out_opcode;

    logic        w_req;
    logic [63:0] w_addr;
    logic [31:0] w_rdata = '0;
    logic        w_redirect = 1'b0;
    logic [63:0] w_redirect_pc = '0;
    logic        w_valid;
    logic        w_ready = 1'b1;
    logic [31:0] w_instr;
    logic [63:0] w_pc;
    logic [6:0]  w_opcode;

    int total = 0;
    int bad = 0;

    logic [31:0] key = '0;
    logic        use_w0 = 1'b0;
    logic [31:0] w0 = '0;

    typedef struct {
        logic [63:0] pc;
        int          age;
    } ent_t;
    ent_t        q[$];
    logic [63:0] m_fetch = '0;

    instruction_fetch #(.PC_W(64), .RESET_PC(64'd0)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc), .out_opcode(out_opcode)
    );

    instruction_fetch #(.PC_W(64), .RESET_PC(WRAP_PC)) dut_w (
        .clk(clk), .reset(reset),
        .imem_req(w_req), .imem_addr(w_addr), .imem_rdata(w_rdata),
        .redirect_valid(w_redirect), .redirect_pc(w_redirect_pc),
        .out_valid(w_valid), .out_ready(w_ready),
        .out_instr(w_instr), .out_pc(w_pc), .out_opcode(w_opcode)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memword(input logic [63:0] a);
        if (use_w0 && a == 64'd0) return w0;
        return a[31:0] ^ key;
    endfunction

    always @(posedge clk) if (imem_req) imem_rdata <= memword(imem_addr);
    always @(posedge clk) if (w_req) w_rdata <= w_addr[31:0];

    // A fetch becomes deliverable once it has survived one full cycle after its issue edge
    function automatic logic exp_valid();
        return q.size() > 0 && q[0].age >= 1;
    endfunction

    function automatic logic exp_req();
        int pend;
        pend = int'(q.size()) - ((exp_valid() && out_ready) ? 1 : 0);
        return reset && !redirect_valid && pend < 2;
    endfunction

    function automatic logic [63:0] exp_pc();
        return exp_valid() ? q[0].pc : 64'd0;
    endfunction

    function automatic logic [31:0] exp_instr();
        return exp_valid() ? memword(q[0].pc) : 32'd0;
    endfunction

    task automatic tick();
        logic pop, req;
        pop = exp_valid() && out_ready;
        req = exp_req();
        @(posedge clk);
        if (!reset) begin
            q.delete();
            m_fetch = 64'd0;
        end else if (redirect_valid) begin
            q.delete();
            m_fetch = redirect_pc & ~64'h3;
        end else begin
            if (pop) void'(q.pop_front());
            for (int i = 0; i < int'(q.size()); i++) q[i].age++;
            if (req) begin
                q.push_back('{pc: m_fetch, age: 0});
                m_fetch = m_fetch + 64'd4;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        out_ready = 1'b1;
        redirect_valid = 1'b0;
        tick();
        tick();
        #1;
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL reset_req: got %b want 0", imem_req); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        total++; if (out_pc !== 64'd0) begin bad++; $display("FAIL reset_pc: got %h want 0", out_pc); end
        total++; if (out_instr !== 32'd0) begin bad++; $display("FAIL reset_instr: got %h want 0", out_instr); end
        total++; if (out_opcode !== 7'd0) begin bad++; $display("FAIL reset_opcode: got %h want 0", out_opcode); end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_stream();
        for (int i = 0; i < 14; i++) begin
            out_ready = 1'b1;
            #1;
            total++; if (imem_req !== exp_req()) begin bad++; $display("FAIL stream_req c%0d: got %b want %b", i, imem_req, exp_req()); end
            total++; if (imem_addr !== m_fetch) begin bad++; $display("FAIL stream_addr c%0d: got %h want %h", i, imem_addr, m_fetch); end
            total++; if (out_valid !== exp_valid()) begin bad++; $display("FAIL stream_valid c%0d: got %b want %b", i, out_valid, exp_valid()); end
            total++; if (out_pc !== exp_pc()) begin bad++; $display("FAIL stream_pc c%0d: got %h want %h", i, out_pc, exp_pc()); end
            if (i >= 2) begin
                total++; if (out_pc !== 64'(4 * (i - 2))) begin bad++; $display("FAIL stream_seq c%0d: got %h want %h", i, out_pc, 64'(4 * (i - 2))); end
                total++; if (out_instr !== out_pc[31:0] || !out_valid) begin bad++; $display("FAIL stream_instr c%0d: got %h want %h", i, out_instr, out_pc[31:0]); end
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 16; i++) begin
            out_ready = (i >= 2 && i < 8) ? 1'b0 : 1'b1;
            #1;
            total++; if (imem_req !== exp_req()) begin bad++; $display("FAIL bp_req c%0d: got %b want %b", i, imem_req, exp_req()); end
            total++; if (out_valid !== exp_valid()) begin bad++; $display("FAIL bp_valid c%0d: got %b want %b", i, out_valid, exp_valid()); end
            total++; if (out_pc !== exp_pc()) begin bad++; $display("FAIL bp_pc c%0d: got %h want %h", i, out_pc, exp_pc()); end
            total++; if (out_instr !== exp_instr()) begin bad++; $display("FAIL bp_instr c%0d: got %h want %h", i, out_instr, exp_instr()); end
            if (i >= 4 && i < 8) begin
                total++; if (imem_req !== 1'b0 || out_valid !== 1'b1) begin bad++; $display("FAIL bp_stall c%0d: got req=%b valid=%b want req=0 valid=1", i, imem_req, out_valid); end
            end
            if (i == 8) begin
                total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL bp_resume_req: got %b want 1", imem_req); end
            end
            tick();
        end
    endtask

    task automatic test_redirect();
        for (int sc = 0; sc < 2; sc++) begin
            out_ready = 1'b1;
            tick();
            tick();
            if (sc == 0) begin
                out_ready = 1'b0;
                tick();
                tick();
                tick();
            end
            redirect_valid = 1'b1;
            redirect_pc = 64'h100;
            out_ready = 1'b1;
            #1;
            total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL redir_req_r sc%0d: got %b want 0", sc, imem_req); end
            tick();
            redirect_valid = 1'b0;
            #1;
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL redir_valid_r1 sc%0d: got %b want 0", sc, out_valid); end
            total++; if (imem_req !== 1'b1 || imem_addr !== 64'h100) begin bad++; $display("FAIL redir_addr_r1 sc%0d: got req=%b addr=%h want req=1 addr=100", sc, imem_req, imem_addr); end
            tick();
            #1;
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL redir_valid_r2 sc%0d: got %b want 0", sc, out_valid); end
            tick();
            #1;
            total++; if (out_valid !== 1'b1 || out_pc !== 64'h100) begin bad++; $display("FAIL redir_first_r3 sc%0d: got valid=%b pc=%h want valid=1 pc=100", sc, out_valid, out_pc); end
            total++; if (out_instr !== memword(64'h100)) begin bad++; $display("FAIL redir_instr_r3 sc%0d: got %h want %h", sc, out_instr, memword(64'h100)); end
            tick();
            #1;
            total++; if (out_pc !== 64'h104) begin bad++; $display("FAIL redir_next_r4 sc%0d: got %h want 104", sc, out_pc); end
            tick();
        end
    endtask

    task automatic test_redirect_burst();
        logic [63:0] tgt [3];
        logic        found;
        tgt[0] = 64'h40;
        tgt[1] = 64'h80;
        tgt[2] = 64'hC0;
        out_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 64'h102;
        tick();
        redirect_valid = 1'b0;
        #1;
        total++; if (imem_req !== 1'b1 || imem_addr !== 64'h100) begin bad++; $display("FAIL unaligned_addr: got req=%b addr=%h want req=1 addr=100", imem_req, imem_addr); end
        tick();
        tick();
        tick();
        for (int t = 0; t < 3; t++) begin
            redirect_valid = 1'b1;
            redirect_pc = tgt[t];
            #1;
            total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL burst_req t%0d: got %b want 0", t, imem_req); end
            tick();
        end
        redirect_valid = 1'b0;
        found = 1'b0;
        for (int t = 0; t < 8 && !found; t++) begin
            #1;
            if (out_valid) begin
                found = 1'b1;
                total++; if (out_pc !== 64'hC0) begin bad++; $display("FAIL burst_first_pc: got %h want c0", out_pc); end
            end
            tick();
        end
        total++; if (!found) begin bad++; $display("FAIL burst_timeout: got no valid want valid within 8 cycles"); end
    endtask

    task automatic test_opcode();
        logic [31:0] words [2];
        logic [6:0]  ops [2];
        words[0] = 32'h00A58533; ops[0] = 7'b0110011;
        words[1] = 32'h0000A303; ops[1] = 7'b0000011;
        for (int k = 0; k < 2; k++) begin
            w0 = words[k];
            use_w0 = 1'b1;
            out_ready = 1'b1;
            reset = 1'b0;
            tick();
            reset = 1'b1;
            tick();
            tick();
            #1;
            total++; if (out_valid !== 1'b1 || out_pc !== 64'd0) begin bad++; $display("FAIL opc_head k%0d: got valid=%b pc=%h want valid=1 pc=0", k, out_valid, out_pc); end
            total++; if (out_opcode !== ops[k]) begin bad++; $display("FAIL opc_value k%0d: got %b want %b", k, out_opcode, ops[k]); end
            tick();
            tick();
        end
        use_w0 = 1'b0;
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        tick();
        tick();
        out_ready = 1'b0;
        tick();
        tick();
        tick();
        #1;
        total++; if (out_valid !== 1'b1 || imem_req !== 1'b0) begin bad++; $display("FAIL rmid_full: got valid=%b req=%b want valid=1 req=0", out_valid, imem_req); end
        #1;
        reset = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0 || out_pc !== 64'd0) begin bad++; $display("FAIL rmid_async: got valid=%b pc=%h want valid=0 pc=0", out_valid, out_pc); end
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rmid_req: got %b want 0", imem_req); end
        tick();
        reset = 1'b1;
        out_ready = 1'b1;
        #1;
        total++; if (imem_req !== 1'b1 || imem_addr !== 64'd0) begin bad++; $display("FAIL rmid_restart: got req=%b addr=%h want req=1 addr=0", imem_req, imem_addr); end
        tick();
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rmid_stale: got %b want 0", out_valid); end
        tick();
        #1;
        total++; if (out_valid !== 1'b1 || out_pc !== 64'd0) begin bad++; $display("FAIL rmid_first: got valid=%b pc=%h want valid=1 pc=0", out_valid, out_pc); end
        tick();
    endtask

    task automatic test_random();
        key = $urandom;
        redirect_valid = 1'b1;
        redirect_pc = 64'h2000;
        out_ready = 1'b1;
        tick();
        for (int i = 0; i < 400; i++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 3) == 0) redirect_pc = {$urandom, $urandom};
            else redirect_pc = 64'($urandom_range(0, 4095));
            #1;
            total++; if (imem_req !== exp_req()) begin bad++; $display("FAIL rnd_req c%0d: got %b want %b", i, imem_req, exp_req()); end
            if (exp_req()) begin
                total++; if (imem_addr !== m_fetch) begin bad++; $display("FAIL rnd_addr c%0d: got %h want %h", i, imem_addr, m_fetch); end
            end
            total++; if (out_valid !== exp_valid()) begin bad++; $display("FAIL rnd_valid c%0d: got %b want %b", i, out_valid, exp_valid()); end
            total++; if (out_pc !== exp_pc()) begin bad++; $display("FAIL rnd_pc c%0d: got %h want %h", i, out_pc, exp_pc()); end
            total++; if (out_instr !== exp_instr()) begin bad++; $display("FAIL rnd_instr c%0d: got %h want %h", i, out_instr, exp_instr()); end
            tick();
        end
        redirect_valid = 1'b0;
        key = '0;
    endtask

    task automatic test_wrap();
        out_ready = 1'b1;
        redirect_valid = 1'b0;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        #1;
        total++; if (w_req !== 1'b1 || w_addr !== WRAP_PC) begin bad++; $display("FAIL wrap_first: got req=%b addr=%h want req=1 addr=%h", w_req, w_addr, WRAP_PC); end
        tick();
        #1;
        total++; if (w_req !== 1'b1 || w_addr !== 64'd0) begin bad++; $display("FAIL wrap_second: got req=%b addr=%h want req=1 addr=0", w_req, w_addr); end
        tick();
        #1;
        total++; if (w_valid !== 1'b1 || w_pc !== WRAP_PC) begin bad++; $display("FAIL wrap_out0: got valid=%b pc=%h want valid=1 pc=%h", w_valid, w_pc, WRAP_PC); end
        tick();
        #1;
        total++; if (w_pc !== 64'd0 || w_instr !== 32'd0) begin bad++; $display("FAIL wrap_out1: got pc=%h instr=%h want pc=0 instr=0", w_pc, w_instr); end
        tick();
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_redirect_burst();
        test_opcode();
        test_reset_mid();
        test_random();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
